// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and state encoding for the IMEM program loader
package imem_loader_pkg;

   localparam int         IMEM_AW = 14;
   localparam int         WC_W    = 15;
   localparam logic [3:0] WEA_ALL = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a byte stream little-endian into 32-bit words and writes them to IMEM
module imem_loader
   import imem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [IMEM_AW-1:0] base_addr,
   input  logic [WC_W-1:0]    word_count,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_din,
   output logic [3:0]         imem_wea,
   output logic               busy,
   output logic               done,
   output logic [7:0]         checksum
);

   state_t             r_state;
   state_t             w_next;
   logic [IMEM_AW-1:0] r_addr;
   logic [WC_W-1:0]    r_remaining;
   logic [31:0]        r_word;
   logic [1:0]         r_idx;
   logic [7:0]         r_checksum;
   logic               w_accept;
   logic               w_last_word;

   assign w_last_word = (r_remaining == WC_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      byte_ready = 1'b0;
      imem_wea   = 4'b0000;
      busy       = 1'b1;
      done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next = (word_count == '0) ? ST_DONE : ST_RECV;
            end
         end
         ST_RECV: begin
            byte_ready = 1'b1;
            w_accept   = byte_valid;
            if (byte_valid && (r_idx == 2'd3)) begin
               w_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            imem_wea = WEA_ALL;
            w_next   = w_last_word ? ST_DONE : ST_RECV;
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // The address only advances when another word follows, so imem_addr
   // stays on the last written word after the load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr      <= '0;
         r_remaining <= '0;
         r_word      <= '0;
         r_idx       <= '0;
         r_checksum  <= '0;
      end else begin
         if ((r_state == ST_IDLE) && start) begin
            r_checksum <= '0;
            r_idx      <= '0;
            if (word_count != '0) begin
               r_addr      <= base_addr;
               r_remaining <= word_count;
               r_word      <= '0;
            end
         end
         if (w_accept) begin
            r_word[{r_idx, 3'b000} +: 8] <= byte_in;
            r_idx                        <= r_idx + 2'd1;
            r_checksum                   <= r_checksum + byte_in;
         end
         if (r_state == ST_WRITE) begin
            r_remaining <= r_remaining - WC_W'(1);
            if (!w_last_word) begin
               r_addr <= r_addr + IMEM_AW'(1);
            end
         end
      end
   end

   assign imem_addr = r_addr;
   assign imem_din  = r_word;
   assign checksum  = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [13:0] base_addr = '0;
   logic [14:0] word_count = '0;
   logic [7:0]  byte_in = '0;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic [13:0] imem_addr;
   logic [31:0] imem_din;
   logic [3:0]  imem_wea;
   logic        busy;
   logic        done;
   logic [7:0]  checksum;

   imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .imem_addr  (imem_addr),
      .imem_din   (imem_din),
      .imem_wea   (imem_wea),
      .busy       (busy),
      .done       (done),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] addr;
      logic [31:0] din;
      logic [3:0]  wea;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [13:0] base;
      logic [14:0] count;
      bit          toggle;
      logic [7:0]  seed;
   } vec_t;

   int         cyc = 0;
   int         n_chk = 0;
   int         n_err = 0;
   int         br_bad = 0;
   int         t_start = 0;
   wr_t        wq[$];
   int         dq[$];
   logic [7:0] tx_q[$];
   vec_t       vecs[4];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_wea != 4'b0000) wq.push_back('{imem_addr, imem_din, imem_wea, cyc});
      if (done) dq.push_back(cyc);
      if (byte_ready && (!busy || done || (imem_wea != 4'b0000))) br_bad <= br_bad + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_start(input logic [13:0] b, input logic [14:0] c);
      wq.delete();
      dq.delete();
      @(negedge clk);
      start = 1'b1;
      base_addr = b;
      word_count = c;
      t_start = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic feed(input bit toggle);
      int  i = 0;
      int  guard = 0;
      bit  ph = 1'b0;
      while (i < tx_q.size() && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (toggle && ph) begin
            byte_valid = 1'b0;
         end else begin
            byte_valid = 1'b1;
            byte_in = tx_q[i];
            if (byte_ready) i++;
         end
         ph = !ph;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      if (guard >= 2000) check("feed_timeout", 32'(i), 32'(tx_q.size()));
   endtask

   task automatic wait_done();
      int g = 0;
      while (dq.size() == 0 && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (dq.size() == 0) check("done_timeout", 32'(0), 32'(1));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [31:0] exp_din;
      logic [7:0]  exp_ck;
      logic [7:0]  b;

      vecs[0] = '{14'h0100, 15'd2, 1'b0, 8'hA0};
      vecs[1] = '{14'h3FFF, 15'd2, 1'b0, 8'h11};
      vecs[2] = '{14'h0040, 15'd2, 1'b1, 8'h5C};
      vecs[3] = '{14'h1234, 15'd4, 1'b0, 8'hF0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_byte_ready", 32'(byte_ready), 32'(0));
      check("rst_imem_addr", 32'(imem_addr), 32'(0));
      check("rst_imem_din", imem_din, 32'(0));
      check("rst_imem_wea", 32'(imem_wea), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_checksum", 32'(checksum), 32'(0));

      // single word, RISC-V addi
      tx_q = '{8'h13, 8'h05, 8'h10, 8'h00};
      do_start(14'h0000, 15'd1);
      check("l1_busy", 32'(busy), 32'(1));
      feed(1'b0);
      wait_done();
      check("l1_nwrites", 32'(wq.size()), 32'(1));
      if (wq.size() >= 1) begin
         check("l1_addr", 32'(wq[0].addr), 32'(0));
         check("l1_din", wq[0].din, 32'h00100513);
         check("l1_wea", 32'(wq[0].wea), 32'hF);
         if (dq.size() >= 1) check("l1_done_after_write", 32'(dq[0] - wq[0].cyc), 32'(1));
      end
      check("l1_ndone", 32'(dq.size()), 32'(1));
      check("l1_checksum", 32'(checksum), 32'h28);
      check("l1_idle", 32'(busy), 32'(0));

      // address wrap across the top of IMEM
      tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
      do_start(14'h3FFE, 15'd3);
      feed(1'b0);
      wait_done();
      check("wrap_nwrites", 32'(wq.size()), 32'(3));
      if (wq.size() >= 3) begin
         check("wrap_a0", 32'(wq[0].addr), 32'h3FFE);
         check("wrap_a1", 32'(wq[1].addr), 32'h3FFF);
         check("wrap_a2", 32'(wq[2].addr), 32'h0000);
         check("wrap_d0", wq[0].din, 32'h04030201);
         check("wrap_d1", wq[1].din, 32'h08070605);
         check("wrap_d2", wq[2].din, 32'h0C0B0A09);
         check("wrap_latency", 32'(wq[1].cyc - wq[0].cyc), 32'(5));
      end
      check("wrap_checksum", 32'(checksum), 32'h4E);

      // zero-length load
      do_start(14'h0123, 15'd0);
      wait_done();
      check("zero_nwrites", 32'(wq.size()), 32'(0));
      check("zero_ndone", 32'(dq.size()), 32'(1));
      if (dq.size() >= 1) check("zero_done_latency", 32'(dq[0] - t_start), 32'(1));
      check("zero_checksum", 32'(checksum), 32'(0));

      for (int v = 0; v < 4; v++) begin
         tx_q.delete();
         exp_ck = '0;
         for (int k = 0; k < 4 * int'(vecs[v].count); k++) begin
            b = vecs[v].seed + 8'(k * 7);
            tx_q.push_back(b);
            exp_ck = exp_ck + b;
         end
         do_start(vecs[v].base, vecs[v].count);
         feed(vecs[v].toggle);
         wait_done();
         check($sformatf("v%0d_nwrites", v), 32'(wq.size()), 32'(vecs[v].count));
         for (int w = 0; w < int'(vecs[v].count) && w < wq.size(); w++) begin
            exp_din = {tx_q[4*w+3], tx_q[4*w+2], tx_q[4*w+1], tx_q[4*w]};
            check($sformatf("v%0d_addr%0d", v, w), 32'(wq[w].addr), 32'(14'(vecs[v].base + 14'(w))));
            check($sformatf("v%0d_din%0d", v, w), wq[w].din, exp_din);
            check($sformatf("v%0d_wea%0d", v, w), 32'(wq[w].wea), 32'hF);
            if (w > 0 && !vecs[v].toggle)
               check($sformatf("v%0d_gap%0d", v, w), 32'(wq[w].cyc - wq[w-1].cyc), 32'(5));
         end
         check($sformatf("v%0d_ndone", v), 32'(dq.size()), 32'(1));
         check($sformatf("v%0d_checksum", v), 32'(checksum), 32'(exp_ck));
         check($sformatf("v%0d_idle", v), 32'(busy), 32'(0));
      end

      // reset mid-word discards the partial word
      tx_q = '{8'h55, 8'h66};
      do_start(14'h0005, 15'd1);
      feed(1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_nwrites", 32'(wq.size()), 32'(0));
      check("mrst_busy", 32'(busy), 32'(0));
      check("mrst_byte_ready", 32'(byte_ready), 32'(0));
      check("mrst_checksum", 32'(checksum), 32'(0));
      check("mrst_addr", 32'(imem_addr), 32'(0));
      tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_start(14'h0007, 15'd1);
      feed(1'b0);
      wait_done();
      check("after_rst_nwrites", 32'(wq.size()), 32'(1));
      if (wq.size() >= 1) begin
         check("after_rst_addr", 32'(wq[0].addr), 32'h0007);
         check("after_rst_din", wq[0].din, 32'hEFBEADDE);
      end
      check("after_rst_checksum", 32'(checksum), 32'h38);

      // start pulsed mid-load must be ignored
      tx_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
      do_start(14'h0010, 15'd2);
      fork
         feed(1'b0);
         begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            base_addr = 14'h0020;
            word_count = 15'd5;
            @(negedge clk);
            start = 1'b0;
         end
      join
      wait_done();
      repeat (10) @(negedge clk);
      check("ign_nwrites", 32'(wq.size()), 32'(2));
      if (wq.size() >= 2) begin
         check("ign_a0", 32'(wq[0].addr), 32'h0010);
         check("ign_a1", 32'(wq[1].addr), 32'h0011);
         check("ign_d0", wq[0].din, 32'h24232221);
         check("ign_d1", wq[1].din, 32'h28272625);
      end
      check("ign_ndone", 32'(dq.size()), 32'(1));
      check("ign_checksum_hold", 32'(checksum), 32'h24);
      check("ign_idle", 32'(busy), 32'(0));

      check("byte_ready_outside_recv", 32'(br_bad), 32'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
